subtractor_8_bit: RTL and testbench

// - 8-bit unsigned subtractor with borrow-in, used by the calculator datapath for the SUB operation.
// - Computes A - B - BorrowIn.
// - Output is registered: one result per clock, one-cycle latency.
// - error flags an unsigned underflow, i.e. a negative true result (borrow out of bit 7).
//

---
 rtl/subtractor_8_bit_if.sv | 25 ++
 rtl/subtractor_8_bit.sv | 37 +++
 tb/tb_subtractor_8_bit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/subtractor_8_bit_if.sv
// Operand/result bundle for the 8-bit subtractor. The master drives operands,
// the slave (the subtractor) returns the registered difference and borrow-out.
interface subtractor_8_bit_if;
  logic [7:0] A;
  logic [7:0] B;
  logic       BorrowIn;
  logic [7:0] Diff;
  logic       error;

  modport master (
    output A,
    output B,
    output BorrowIn,
    input  Diff,
    input  error
  );

  modport slave (
    input  A,
    input  B,
    input  BorrowIn,
    output Diff,
    output error
  );
endinterface : subtractor_8_bit_if

// File: rtl/subtractor_8_bit.sv
// 8-bit unsigned ripple-borrow subtractor, Diff = A - B - BorrowIn, with the
// difference and the borrow-out (underflow flag) registered for one-cycle latency.
module subtractor_8_bit (
  input  logic                 clk,
  input  logic                 rst_n,
  subtractor_8_bit_if.slave    bus
);

  logic [8:0] w_bw;
  logic [7:0] w_d;
  logic [7:0] r_diff;
  logic       r_error;

  assign w_bw[0] = bus.BorrowIn;

  // One full subtractor per bit; the borrow ripples from bit 0 up to bit 7.
  for (genvar i = 0; i < 8; i++) begin : g_fs
    assign w_d[i]    = bus.A[i] ^ bus.B[i] ^ w_bw[i];
    assign w_bw[i+1] = (~bus.A[i] & bus.B[i]) | (~(bus.A[i] ^ bus.B[i]) & w_bw[i]);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff  <= 8'h00;
      r_error <= 1'b0;
    end else begin
      r_diff  <= w_d;
      r_error <= w_bw[8];
    end
  end

  assign bus.Diff  = r_diff;
  assign bus.error = r_error;

endmodule : subtractor_8_bit

// File: tb/tb_subtractor_8_bit.sv
// Self-checking bench for subtractor_8_bit: expected {error, Diff} values are
// queued when operands are driven and compared one clock later.
module tb_subtractor_8_bit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  subtractor_8_bit_if u_if ();

  subtractor_8_bit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  logic [8:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got error=%0b Diff=%02h, expected error=%0b Diff=%02h",
               tag, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b,
                                         input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'b0, bi};
  endfunction

  function automatic logic [8:0] dut_out();
    return {u_if.error, u_if.Diff};
  endfunction

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic bi);
    u_if.A        = a;
    u_if.B        = b;
    u_if.BorrowIn = bi;
  endtask

  // Drive on the falling edge, push the expectation, check just after the next rising edge.
  task automatic drive(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
    logic [8:0] exp;
    @(negedge clk);
    set_inputs(a, b, bi);
    exp_q.push_back(ref_sub(a, b, bi));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, dut_out(), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] exp;

    set_inputs(8'h0F, 8'h05, 1'b0);
    #2;
    check("rst_pre_edge", dut_out(), 9'h000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_at_edge", dut_out(), 9'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    drive("vec_0f_05_0", 8'h0F, 8'h05, 1'b0);
    drive("vec_aa_55_1", 8'hAA, 8'h55, 1'b1);
    drive("vec_f0_0f_0", 8'hF0, 8'h0F, 1'b0);
    drive("max_underflow", 8'h00, 8'hFF, 1'b1);
    drive("eq_bi0", 8'h81, 8'h81, 1'b0);
    drive("eq_bi1", 8'h81, 8'h81, 1'b1);
    drive("ff_minus_0", 8'hFF, 8'h00, 1'b0);
    drive("zero_minus_1", 8'h00, 8'h01, 1'b0);

    // Back-to-back: each drive lands on the cycle right after the previous one.
    drive("b2b_0", 8'h10, 8'h01, 1'b0);
    drive("b2b_1", 8'h01, 8'h10, 1'b0);
    drive("b2b_2", 8'h7F, 8'h80, 1'b1);
    drive("b2b_3", 8'h80, 8'h7F, 1'b1);

    // Asynchronous reset mid-stream.
    drive("pre_rst", 8'h0F, 8'h05, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", dut_out(), 9'h000);
    @(posedge clk);
    #1;
    check("rst_hold", dut_out(), 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    set_inputs(8'hAA, 8'h55, 1'b1);
    exp_q.push_back(ref_sub(8'hAA, 8'h55, 1'b1));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("post_rst_first", dut_out(), exp);

    for (int i = 0; i < 1000; i++) begin
      drive("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_subtractor_8_bit
